nth_root_engine: RTL

- Parametrised iterative n-th root unit: out = floor(X^(1/n) * 2^FRAC_W) for an unsigned integer radicand X and a runtime degree n.
- Binary search, MSB-first, one result bit per trial. Trial^n comes from a sequential power sub-unit, so area is one multiplier, not MAX_N.
- Successor of the single-shot root block. Adds ready/valid handshakes on both sides, output backpressure, degree-range error reporting and an exactness flag.
- Sits between the operand capture stage and the result collector in the arithmetic datapath.

---
 rtl/nth_root_pkg.sv | 25 ++
 rtl/pow_seq.sv | 43 ++++
 rtl/nth_root_engine.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/nth_root_pkg.sv
// Shared types, width helpers and default sizing for the n-th root engine.
// Build option ROOT_ROUND_EN (see nth_root_engine) changes only the top-level datapath.
package nth_root_pkg;

    localparam int DEF_IN_W   = 10;
    localparam int DEF_FRAC_W = 10;
    localparam int DEF_MAX_N  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_POW,
        ST_CMP,
        ST_DONE
    } state_t;

    function automatic int calc_out_w(input int in_w, input int frac_w);
        return in_w + frac_w;
    endfunction

    function automatic int calc_prod_w(input int max_n, input int out_w);
        return max_n * out_w;
    endfunction

endpackage

// File: rtl/pow_seq.sv
// Sequential power unit: result = base^n using one multiplier, one product per cycle.
// o_done is high in the cycle whose clock edge produces the final product.
module pow_seq #(
    parameter int BASE_W = 20,
    parameter int PROD_W = 140,
    parameter int N_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [BASE_W-1:0] i_base,
    input  logic [N_W-1:0]    i_n,
    output logic              o_done,
    output logic [PROD_W-1:0] o_result
);

    logic [BASE_W-1:0] r_base;
    logic [N_W-1:0]    r_cnt;
    logic [PROD_W-1:0] r_result;
    logic [PROD_W-1:0] w_prod;

    // The true product always fits PROD_W, so keeping the low half loses nothing.
    assign w_prod = r_result * {{(PROD_W-BASE_W){1'b0}}, r_base};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (i_start) begin
            r_base   <= i_base;
            r_result <= {{(PROD_W-BASE_W){1'b0}}, i_base};
            r_cnt    <= i_n - N_W'(1);
        end else if (r_cnt != '0) begin
            r_result <= w_prod;
            r_cnt    <= r_cnt - N_W'(1);
        end
    end

    assign o_done   = (r_cnt == N_W'(1));
    assign o_result = r_result;

endmodule

// File: rtl/nth_root_engine.sv
// Iterative n-th root: out = floor(X^(1/n) * 2^FRAC_W), one result bit per trial.
// Optional macro ROOT_ROUND_EN: extra guard-bit trial and round-half-up output.
module nth_root_engine
    import nth_root_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int MAX_N  = DEF_MAX_N
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_W-1:0]                    in_data,
    input  logic [$clog2(MAX_N+1)-1:0]         in_n,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [calc_out_w(IN_W,FRAC_W)-1:0] out_data,
    output logic                               out_exact,
    output logic                               out_err
);

    localparam int OUT_W  = calc_out_w(IN_W, FRAC_W);
    localparam int PROD_W = calc_prod_w(MAX_N, OUT_W);
`ifdef ROOT_ROUND_EN
    localparam int GUARD_W = 1;
`else
    localparam int GUARD_W = 0;
`endif
    localparam int N_W    = $clog2(MAX_N + 1);
    localparam int ACC_W  = OUT_W + GUARD_W;
    localparam int PW     = PROD_W + GUARD_W * MAX_N;
    localparam int BIT_W  = $clog2(ACC_W);
    localparam int FS     = FRAC_W + GUARD_W;
    localparam int SH_W   = $clog2(MAX_N * FS + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IN_W-1:0]    r_x;
    logic [N_W-1:0]     r_n;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_trial;
    logic [BIT_W-1:0]   r_bit;
    logic               r_exact;
    logic               r_err;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_exact;
    logic               r_out_err;

    logic               w_accept;
    logic               w_bad_n;
    logic               w_unit_n;
    logic               w_zero_x;
    logic               w_bypass;
    logic [ACC_W-1:0]   w_onehot;
    logic [ACC_W-1:0]   w_trial;
    logic               w_pow_start;
    logic               w_pow_done;
    logic [PW-1:0]      w_pow;
    logic [SH_W-1:0]    w_shamt;
    logic [PW-1:0]      w_target;
    logic               w_lt;
    logic               w_eq;
    logic               w_eq_exact;
    logic [OUT_W-1:0]   w_final;

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;

    assign w_bad_n   = (in_n == '0) || (in_n > N_W'(MAX_N));
    assign w_unit_n  = (in_n == N_W'(1));
    assign w_zero_x  = (in_data == '0);
    assign w_bypass  = w_bad_n || w_unit_n || w_zero_x;

    assign w_onehot    = ACC_W'(1) << r_bit;
    assign w_trial     = r_acc | w_onehot;
    assign w_pow_start = (r_state == ST_LOAD);

    pow_seq #(
        .BASE_W (ACC_W),
        .PROD_W (PW),
        .N_W    (N_W)
    ) u_pow_seq (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_pow_start),
        .i_base   (w_trial),
        .i_n      (r_n),
        .o_done   (w_pow_done),
        .o_result (w_pow)
    );

    // Compare trial^n against X scaled into the same fixed-point domain.
    assign w_shamt  = SH_W'(r_n) * SH_W'(FS);
    assign w_target = PW'(r_x) << w_shamt;
    assign w_lt     = (w_pow < w_target);
    assign w_eq     = (w_pow == w_target);

`ifdef ROOT_ROUND_EN
    logic [OUT_W:0] w_round_sum;

    // A match found while probing the guard bit means the root sits on a half LSB.
    assign w_eq_exact  = (r_bit != '0);
    assign w_round_sum = {1'b0, r_acc[ACC_W-1:1]} + {{OUT_W{1'b0}}, r_acc[0]};
    assign w_final     = w_round_sum[OUT_W] ? '1 : w_round_sum[OUT_W-1:0];
`else
    assign w_eq_exact  = 1'b1;
    assign w_final     = r_acc;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_bypass ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: w_state_next = ST_POW;
            ST_POW: begin
                if (w_pow_done) begin
                    w_state_next = ST_CMP;
                end
            end
            ST_CMP: begin
                if (w_eq || (r_bit == '0)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_n         <= '0;
            r_acc       <= '0;
            r_trial     <= '0;
            r_bit       <= '0;
            r_exact     <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_exact <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x     <= in_data;
                        r_n     <= in_n;
                        r_bit   <= BIT_W'(ACC_W - 1);
                        r_acc   <= '0;
                        r_exact <= 1'b0;
                        r_err   <= 1'b0;
                        if (w_bad_n) begin
                            r_err <= 1'b1;
                        end else if (w_unit_n) begin
                            r_acc   <= ACC_W'(in_data) << FS;
                            r_exact <= 1'b1;
                        end else if (w_zero_x) begin
                            r_exact <= 1'b1;
                        end
                    end
                end
                ST_LOAD: r_trial <= w_trial;
                ST_CMP: begin
                    if (w_lt || w_eq) begin
                        r_acc <= r_trial;
                    end
                    if (w_eq) begin
                        r_exact <= w_eq_exact;
                    end else if (r_bit != '0) begin
                        r_bit <= r_bit - BIT_W'(1);
                    end
                end
                ST_DONE: begin
                    // First DONE cycle finalises the result; later cycles hold it for the consumer.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_final;
                        r_out_exact <= r_exact;
                        r_out_err   <= r_err;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_exact = r_out_exact;
    assign out_err   = r_out_err;

endmodule
